br_resolve_unit: RTL and testbench

//  Sits directly downstream of the ALU branch/jump comparator. Captures per-instruction

---
 rtl/br_resolve_unit_if.sv | 42 ++++
 rtl/br_resolve_unit.sv | 129 ++++++++++++
 tb/tb_br_resolve_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/br_resolve_unit_if.sv
// Resolution input, ROB control, fetch redirect and predictor-update bundle.
// slave = resolve unit side, master = surrounding pipeline side.
interface br_resolve_unit_if #(
    parameter int ADDR      = 32,
    parameter int ROB_DEPTH = 32
);
    localparam int ROB = $clog2(ROB_DEPTH);

    logic            in_valid;
    logic            in_ready;
    logic [ROB-1:0]  in_rob_id;
    logic            in_jump;
    logic            in_br_res;
    logic            in_pred_miss_;
    logic            in_jump_miss_;
    logic [ADDR-1:0] in_target;
    logic [ROB-1:0]  rob_head;
    logic            rob_flush;
    logic            redir_valid;
    logic [ADDR-1:0] redir_addr;
    logic [ROB-1:0]  redir_rob_id;
    logic            redir_ack;
    logic            upd_valid;
    logic            upd_ready;
    logic [ROB-1:0]  upd_rob_id;
    logic            upd_taken;
    logic            upd_miss;

    modport slave (
        input  in_valid, in_rob_id, in_jump, in_br_res, in_pred_miss_, in_jump_miss_,
               in_target, rob_head, rob_flush, redir_ack, upd_ready,
        output in_ready, redir_valid, redir_addr, redir_rob_id,
               upd_valid, upd_rob_id, upd_taken, upd_miss
    );

    modport master (
        output in_valid, in_rob_id, in_jump, in_br_res, in_pred_miss_, in_jump_miss_,
               in_target, rob_head, rob_flush, redir_ack, upd_ready,
        input  in_ready, redir_valid, redir_addr, redir_rob_id,
               upd_valid, upd_rob_id, upd_taken, upd_miss
    );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch/jump resolution: holds the oldest mispredict redirect and queues predictor updates.
// Update record appears 1 cycle after accept; in_ready drops when the update FIFO is full.
module br_resolve_unit #(
    parameter int ADDR      = 32,
    parameter int ROB_DEPTH = 32,
    parameter int UPD_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_,
    br_resolve_unit_if.slave   bus
);
    localparam int ROB = $clog2(ROB_DEPTH);
    localparam int PW  = $clog2(UPD_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(UPD_DEPTH);

    typedef enum logic [1:0] {IDLE, PEND, SQUASH} state_t;

    typedef struct packed {
        logic [ROB-1:0] id;
        logic           taken;
        logic           miss;
    } rec_t;

    state_t          state_q;
    logic            redir_vld_q;
    logic [ADDR-1:0] redir_addr_q;
    logic [ROB-1:0]  redir_id_q;
    logic [ROB-1:0]  sq_id_q;

    rec_t            mem_q [UPD_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [PW:0]     cnt_q, cnt_d;
    logic            in_ready_q, upd_vld_q;

    logic [ROB-1:0]  age_in, age_redir, age_sq;
    logic            squashed, accept, miss, acc_miss, pop;
    rec_t            rec_d;

    always_comb begin
        // Ages are distances from the ROB head, so wrap-around compares correctly.
        age_in    = bus.in_rob_id - bus.rob_head;
        age_redir = redir_id_q - bus.rob_head;
        age_sq    = sq_id_q - bus.rob_head;
        squashed  = (state_q == SQUASH) && (age_in > age_sq);
        accept    = bus.in_valid && in_ready_q && !squashed;
        miss      = bus.in_jump ? !bus.in_jump_miss_ : !bus.in_pred_miss_;
        acc_miss  = accept && miss;
        pop       = upd_vld_q && bus.upd_ready;
        rec_d.id    = bus.in_rob_id;
        rec_d.taken = bus.in_jump ? 1'b1 : bus.in_br_res;
        rec_d.miss  = miss;
        cnt_d     = cnt_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < UPD_DEPTH; i++) mem_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            upd_vld_q  <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_q] <= rec_d;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) rd_q <= rd_q + PW'(1);
            cnt_q      <= cnt_d;
            in_ready_q <= (cnt_d != FULL);
            upd_vld_q  <= (cnt_d != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= IDLE;
            redir_vld_q  <= 1'b0;
            redir_addr_q <= '0;
            redir_id_q   <= '0;
            sq_id_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.rob_flush && acc_miss) begin
                        redir_id_q   <= bus.in_rob_id;
                        redir_addr_q <= bus.in_target;
                        redir_vld_q  <= 1'b1;
                        state_q      <= PEND;
                    end
                end
                PEND: begin
                    if (bus.rob_flush) begin
                        redir_vld_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (acc_miss && (age_in < age_redir)) begin
                        // An older miss supersedes the held redirect, even while it is acked.
                        redir_id_q   <= bus.in_rob_id;
                        redir_addr_q <= bus.in_target;
                    end else if (bus.redir_ack) begin
                        redir_vld_q <= 1'b0;
                        sq_id_q     <= redir_id_q;
                        state_q     <= SQUASH;
                    end
                end
                SQUASH: begin
                    if (bus.rob_flush) begin
                        state_q <= IDLE;
                    end else if (acc_miss && (age_in < age_sq)) begin
                        redir_id_q   <= bus.in_rob_id;
                        redir_addr_q <= bus.in_target;
                        redir_vld_q  <= 1'b1;
                        state_q      <= PEND;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.redir_valid  = redir_vld_q;
    assign bus.redir_addr   = redir_addr_q;
    assign bus.redir_rob_id = redir_id_q;
    assign bus.upd_valid    = upd_vld_q;
    assign bus.upd_rob_id   = mem_q[rd_q].id;
    assign bus.upd_taken    = mem_q[rd_q].taken;
    assign bus.upd_miss     = mem_q[rd_q].miss;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Bench for br_resolve_unit: directed redirect checks plus an update-record scoreboard.
module tb_br_resolve_unit;
    logic clk = 1'b0;
    logic reset_;

    br_resolve_unit_if #(.ADDR(32), .ROB_DEPTH(32)) bif ();

    br_resolve_unit #(.ADDR(32), .ROB_DEPTH(32), .UPD_DEPTH(4)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id;
        logic       taken;
        logic       miss;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_r;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] id, input bit jump, input bit res, input bit mis,
                        input logic [31:0] tgt, input bit exp_push);
        exp_t e;
        bif.in_valid      = 1'b1;
        bif.in_rob_id     = id;
        bif.in_jump       = jump;
        bif.in_br_res     = res;
        bif.in_pred_miss_ = jump ? 1'b1 : !mis;
        bif.in_jump_miss_ = jump ? !mis : 1'b1;
        bif.in_target     = tgt;
        if (exp_push) begin
            e.id    = id;
            e.taken = jump ? 1'b1 : res;
            e.miss  = mis;
            exp_q.push_back(e);
        end
        step();
        bif.in_valid = 1'b0;
    endtask

    task automatic flush();
        bif.rob_flush = 1'b1;
        step();
        bif.rob_flush = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_ && bif.upd_valid && bif.upd_ready) begin
            if (exp_q.size() == 0) begin
                chk("upd_extra", 64'(bif.upd_rob_id), 64'h0ff);
            end else begin
                mon_r = exp_q.pop_front();
                chk("upd_rob_id", 64'(bif.upd_rob_id), 64'(mon_r.id));
                chk("upd_taken",  64'(bif.upd_taken),  64'(mon_r.taken));
                chk("upd_miss",   64'(bif.upd_miss),   64'(mon_r.miss));
            end
        end
    end

    initial begin
        reset_            = 1'b0;
        bif.in_valid      = 1'b0;
        bif.in_rob_id     = '0;
        bif.in_jump       = 1'b0;
        bif.in_br_res     = 1'b0;
        bif.in_pred_miss_ = 1'b1;
        bif.in_jump_miss_ = 1'b1;
        bif.in_target     = '0;
        bif.rob_head      = '0;
        bif.rob_flush     = 1'b0;
        bif.redir_ack     = 1'b0;
        bif.upd_ready     = 1'b1;
        step();
        step();
        chk("rst_redir_valid", 64'(bif.redir_valid), 64'h0);
        chk("rst_redir_addr",  64'(bif.redir_addr),  64'h0);
        chk("rst_redir_id",    64'(bif.redir_rob_id), 64'h0);
        chk("rst_upd_valid",   64'(bif.upd_valid),   64'h0);
        chk("rst_upd_id",      64'(bif.upd_rob_id),  64'h0);
        chk("rst_in_ready",    64'(bif.in_ready),    64'h1);
        reset_ = 1'b1;
        step();

        // 1: correct taken branch
        send(5'd5, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_redir_valid", 64'(bif.redir_valid), 64'h0);
        chk("t1_upd_valid",   64'(bif.upd_valid),   64'h1);
        step();
        chk("t1_upd_drained", 64'(bif.upd_valid),   64'h0);

        // 2: jump mispredict held until ack, then squash of younger id
        send(5'd3, 1'b1, 1'b1, 1'b1, 32'h1000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t2_hold_valid", 64'(bif.redir_valid), 64'h1);
            chk("t2_hold_addr",  64'(bif.redir_addr),  64'h1000);
            chk("t2_hold_id",    64'(bif.redir_rob_id), 64'h3);
            step();
        end
        bif.redir_ack = 1'b1;
        step();
        bif.redir_ack = 1'b0;
        chk("t2_ack_valid", 64'(bif.redir_valid), 64'h0);
        send(5'd7, 1'b0, 1'b1, 1'b1, 32'h7000, 1'b0);
        chk("t2_sq_no_redir", 64'(bif.redir_valid), 64'h0);
        flush();

        // 3: older miss replaces, younger ignored, ack with older miss same cycle
        bif.rob_head = 5'd8;
        send(5'd10, 1'b0, 1'b1, 1'b1, 32'h2000, 1'b1);
        chk("t3_id10", 64'(bif.redir_rob_id), 64'd10);
        send(5'd9, 1'b0, 1'b0, 1'b1, 32'h2100, 1'b1);
        chk("t3_id9",   64'(bif.redir_rob_id), 64'd9);
        chk("t3_addr9", 64'(bif.redir_addr),   64'h2100);
        send(5'd12, 1'b0, 1'b1, 1'b1, 32'h2200, 1'b1);
        chk("t3_keep9",    64'(bif.redir_rob_id), 64'd9);
        chk("t3_keepaddr", 64'(bif.redir_addr),   64'h2100);
        bif.redir_ack = 1'b1;
        send(5'd8, 1'b1, 1'b1, 1'b1, 32'h2300, 1'b1);
        chk("t3_ackrepl_valid", 64'(bif.redir_valid), 64'h1);
        chk("t3_ackrepl_id",    64'(bif.redir_rob_id), 64'd8);
        step();
        bif.redir_ack = 1'b0;
        chk("t3_ack_valid", 64'(bif.redir_valid), 64'h0);
        flush();

        // 4: age wrap around ROB head
        bif.rob_head = 5'd30;
        send(5'd1, 1'b0, 1'b1, 1'b1, 32'h3000, 1'b1);
        chk("t4_id1", 64'(bif.redir_rob_id), 64'd1);
        send(5'd31, 1'b0, 1'b1, 1'b1, 32'h3100, 1'b1);
        chk("t4_id31", 64'(bif.redir_rob_id), 64'd31);
        send(5'd2, 1'b0, 1'b1, 1'b1, 32'h3200, 1'b1);
        chk("t4_keep31", 64'(bif.redir_rob_id), 64'd31);
        chk("t4_addr",   64'(bif.redir_addr),   64'h3100);
        flush();
        chk("t4_flush_valid", 64'(bif.redir_valid), 64'h0);

        // 5: squash window, older miss re-arms, flush returns to idle
        bif.rob_head = 5'd0;
        send(5'd4, 1'b0, 1'b1, 1'b1, 32'h4000, 1'b1);
        bif.redir_ack = 1'b1;
        step();
        bif.redir_ack = 1'b0;
        send(5'd6, 1'b0, 1'b1, 1'b1, 32'h4600, 1'b0);
        chk("t5_sq_valid", 64'(bif.redir_valid), 64'h0);
        send(5'd2, 1'b0, 1'b1, 1'b1, 32'h4200, 1'b1);
        chk("t5_old_valid", 64'(bif.redir_valid), 64'h1);
        chk("t5_old_id",    64'(bif.redir_rob_id), 64'd2);
        chk("t5_old_addr",  64'(bif.redir_addr),   64'h4200);
        flush();
        chk("t5_flush_valid", 64'(bif.redir_valid), 64'h0);
        send(5'd6, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_idle_valid", 64'(bif.redir_valid), 64'h0);
        step();
        step();

        // 6: FIFO fill, full backpressure, in-order drain
        bif.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t6_ready_before", 64'(bif.in_ready), 64'h1);
            send(5'(20 + i), 1'b0, 1'(i % 2), 1'b0, 32'h0, 1'b1);
        end
        chk("t6_full_ready", 64'(bif.in_ready), 64'h0);
        send(5'd25, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t6_still_full", 64'(bif.in_ready), 64'h0);
        bif.upd_ready = 1'b1;
        step();
        chk("t6_ready_after_pop", 64'(bif.in_ready), 64'h1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("t6_drain_left", 64'(exp_q.size()), 64'h0);
        chk("t6_empty", 64'(bif.upd_valid), 64'h0);

        // reset asserted while a redirect is pending
        bif.upd_ready = 1'b0;
        send(5'd5, 1'b0, 1'b1, 1'b1, 32'h5000, 1'b1);
        chk("t6_pend_valid", 64'(bif.redir_valid), 64'h1);
        chk("t6_pend_upd",   64'(bif.upd_valid),   64'h1);
        reset_ = 1'b0;
        #2;
        chk("t6_rst_valid",  64'(bif.redir_valid), 64'h0);
        chk("t6_rst_addr",   64'(bif.redir_addr),  64'h0);
        chk("t6_rst_id",     64'(bif.redir_rob_id), 64'h0);
        chk("t6_rst_upd",    64'(bif.upd_valid),   64'h0);
        chk("t6_rst_updid",  64'(bif.upd_rob_id),  64'h0);
        chk("t6_rst_ready",  64'(bif.in_ready),    64'h1);
        exp_q.delete();
        step();
        reset_ = 1'b1;
        bif.upd_ready = 1'b1;
        step();
        step();
        chk("end_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
